// File: rtl/pwm_csr_bank_if.sv
// Byte-level link between the SPI front end and the CSR/PWM bank.
// The SPI side is the master; the CSR bank is the slave.
interface pwm_csr_bank_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] data_in;
  logic                  data_rdy;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  data_latch;

  modport master (output data_in, output data_rdy, input data_out, input data_latch);
  modport slave  (input data_in, input data_rdy, output data_out, output data_latch);
endinterface

// File: rtl/pwm_csr_bank.sv
// Byte-command CSR decoder driving an N-channel PWM bank with a shared prescaler/period,
// double-buffered period/duty, per-channel enable/polarity and a GPIO override.
module pwm_csr_bank #(
  parameter int                    DATA_WIDTH = 8,
  parameter int                    ADDR_WIDTH = 6,
  parameter int                    N_CH       = 4,
  parameter logic [DATA_WIDTH-1:0] ID_VALUE   = 8'hA5
) (
  input  logic                  clk,
  input  logic                  rst,
  pwm_csr_bank_if.slave         bus,
  output logic [DATA_WIDTH-1:0] out
);
  localparam int CW = 2 * DATA_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] A_CTRL  = ADDR_WIDTH'(0);
  localparam logic [ADDR_WIDTH-1:0] A_PRESC = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] A_PER_H = ADDR_WIDTH'(2);
  localparam logic [ADDR_WIDTH-1:0] A_PER_L = ADDR_WIDTH'(3);
  localparam logic [ADDR_WIDTH-1:0] A_GPIO  = ADDR_WIDTH'(4);
  localparam logic [ADDR_WIDTH-1:0] A_CH_EN = ADDR_WIDTH'(5);
  localparam logic [ADDR_WIDTH-1:0] A_POL   = ADDR_WIDTH'(6);
  localparam logic [ADDR_WIDTH-1:0] A_ID    = ADDR_WIDTH'(7);

  typedef enum logic [1:0] {CMD, WDATA, BURST} state_t;

  state_t                  state_reg, state_next;
  logic [ADDR_WIDTH-1:0]   addr_reg, addr_next, cmd_addr;
  logic [1:0]              op;
  logic                    byte_ok, wr_en, rd_en;
  logic [DATA_WIDTH-1:0]   rd_data, data_out_reg;
  logic                    data_latch_reg;

  logic                    pwm_en_reg, gpio_mode_reg, cnt_clr_reg;
  logic [DATA_WIDTH-1:0]   prescale_reg, gpio_out_reg;
  logic [N_CH-1:0]         ch_en_reg, ch_pol_reg;
  logic [CW-1:0]           period_sh_reg, period_act_reg;
  logic [CW-1:0]           duty_sh_reg  [N_CH];
  logic [CW-1:0]           duty_act_reg [N_CH];

  logic [CW-1:0]           counter_reg;
  logic [DATA_WIDTH-1:0]   presc_cnt_reg;
  logic                    tick, wrap, load;
  logic [DATA_WIDTH-1:0]   out_next, out_reg;

  assign op       = bus.data_in[DATA_WIDTH-1 -: 2];
  assign cmd_addr = bus.data_in[ADDR_WIDTH-1:0];
  // Bytes arriving while a read result is being presented are dropped.
  assign byte_ok  = bus.data_rdy & ~data_latch_reg;

  assign bus.data_out   = data_out_reg;
  assign bus.data_latch = data_latch_reg;
  assign out            = out_reg;

  always_comb begin
    state_next = state_reg;
    addr_next  = addr_reg;
    wr_en      = 1'b0;
    rd_en      = 1'b0;
    case (state_reg)
      CMD: if (byte_ok) begin
        addr_next = cmd_addr;
        case (op)
          2'b10:   state_next = WDATA;
          2'b11:   state_next = BURST;
          2'b01:   rd_en = 1'b1;
          default: ;
        endcase
      end
      WDATA: if (byte_ok) begin
        wr_en      = 1'b1;
        state_next = CMD;
      end
      BURST: if (byte_ok) begin
        if (bus.data_in == '0) begin
          state_next = CMD;
        end else begin
          wr_en     = 1'b1;
          addr_next = addr_reg + 1'b1;
        end
      end
      default: state_next = CMD;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= CMD;
      addr_reg       <= '0;
      data_out_reg   <= '0;
      data_latch_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      addr_reg       <= addr_next;
      data_latch_reg <= rd_en;
      if (rd_en) data_out_reg <= rd_data;
    end
  end

  // Read mux is keyed on the command byte itself so the result is ready one cycle later.
  always_comb begin
    rd_data = '0;
    case (cmd_addr)
      A_CTRL:  rd_data[1:0] = {gpio_mode_reg, pwm_en_reg};
      A_PRESC: rd_data = prescale_reg;
      A_PER_H: rd_data = period_sh_reg[CW-1:DATA_WIDTH];
      A_PER_L: rd_data = period_sh_reg[DATA_WIDTH-1:0];
      A_GPIO:  rd_data = gpio_out_reg;
      A_CH_EN: rd_data[N_CH-1:0] = ch_en_reg;
      A_POL:   rd_data[N_CH-1:0] = ch_pol_reg;
      A_ID:    rd_data = ID_VALUE;
      default: ;
    endcase
    for (int i = 0; i < N_CH; i++) begin
      if (cmd_addr == ADDR_WIDTH'(8 + 2 * i)) rd_data = duty_sh_reg[i][CW-1:DATA_WIDTH];
      if (cmd_addr == ADDR_WIDTH'(9 + 2 * i)) rd_data = duty_sh_reg[i][DATA_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pwm_en_reg    <= 1'b0;
      gpio_mode_reg <= 1'b0;
      cnt_clr_reg   <= 1'b0;
      prescale_reg  <= '0;
      period_sh_reg <= '0;
      gpio_out_reg  <= '0;
      ch_en_reg     <= '0;
      ch_pol_reg    <= '0;
    end else begin
      cnt_clr_reg <= 1'b0;
      if (wr_en) begin
        case (addr_reg)
          A_CTRL: begin
            pwm_en_reg    <= bus.data_in[0];
            gpio_mode_reg <= bus.data_in[1];
            cnt_clr_reg   <= bus.data_in[2];
          end
          A_PRESC: prescale_reg <= bus.data_in;
          A_PER_H: period_sh_reg[CW-1:DATA_WIDTH] <= bus.data_in;
          A_PER_L: period_sh_reg[DATA_WIDTH-1:0] <= bus.data_in;
          A_GPIO:  gpio_out_reg <= bus.data_in;
          A_CH_EN: ch_en_reg <= bus.data_in[N_CH-1:0];
          A_POL:   ch_pol_reg <= bus.data_in[N_CH-1:0];
          default: ;
        endcase
      end
    end
  end

  assign tick = pwm_en_reg && (presc_cnt_reg == prescale_reg);
  assign wrap = tick && (counter_reg == period_act_reg);
  // Nonblocking load means a shadow write coinciding with wrap takes effect one period later.
  assign load = cnt_clr_reg | wrap | ~pwm_en_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc_cnt_reg  <= '0;
      counter_reg    <= '0;
      period_act_reg <= '0;
    end else begin
      if (cnt_clr_reg) begin
        presc_cnt_reg <= '0;
        counter_reg   <= '0;
      end else if (pwm_en_reg) begin
        presc_cnt_reg <= tick ? '0 : presc_cnt_reg + 1'b1;
        if (tick) counter_reg <= wrap ? '0 : counter_reg + 1'b1;
      end
      if (load) period_act_reg <= period_sh_reg;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_ch
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          duty_sh_reg[gi]  <= '0;
          duty_act_reg[gi] <= '0;
        end else begin
          if (wr_en && addr_reg == ADDR_WIDTH'(8 + 2 * gi))
            duty_sh_reg[gi][CW-1:DATA_WIDTH] <= bus.data_in;
          if (wr_en && addr_reg == ADDR_WIDTH'(9 + 2 * gi))
            duty_sh_reg[gi][DATA_WIDTH-1:0] <= bus.data_in;
          if (load) duty_act_reg[gi] <= duty_sh_reg[gi];
        end
      end
      assign out_next[gi] = gpio_mode_reg ? gpio_out_reg[gi]
                          : ((ch_en_reg[gi] & (counter_reg < duty_act_reg[gi])) ^ ch_pol_reg[gi]);
    end
    for (gi = N_CH; gi < DATA_WIDTH; gi++) begin : g_gpio
      assign out_next[gi] = gpio_out_reg[gi];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) out_reg <= '0;
    else      out_reg <= out_next;
  end
endmodule

// File: tb/tb_pwm_csr_bank.sv
// Directed + randomized checks of pwm_csr_bank against a CSR array model and
// closed-form PWM duty arithmetic.
module tb_pwm_csr_bank;
  localparam int DW  = 8;
  localparam int AW  = 6;
  localparam int NCH = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [DW-1:0] out;
  int            tests = 0;
  int            fails = 0;
  logic [7:0]    exp_csr [64];

  pwm_csr_bank_if #(.DATA_WIDTH(DW)) bus();

  pwm_csr_bank #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .N_CH(NCH), .ID_VALUE(8'hA5)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus), .out(out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 64; i++) exp_csr[i] = 8'h00;
  endtask

  task automatic model_write(input int a, input logic [7:0] d);
    if (a == 0)                exp_csr[0] = d & 8'h03;
    else if (a == 5 || a == 6) exp_csr[a] = d & 8'h0F;
    else if (a == 7)           ;
    else if (a < 8 + 2 * NCH)  exp_csr[a] = d;
  endtask

  function automatic logic [7:0] exp_read(input int a);
    return (a == 7) ? 8'hA5 : exp_csr[a];
  endfunction

  task automatic send_byte(input logic [7:0] b);
    repeat (2) @(posedge clk);
    #1;
    bus.data_in  = b;
    bus.data_rdy = 1'b1;
    @(posedge clk);
    #1;
    bus.data_rdy = 1'b0;
  endtask

  task automatic write_csr(input int a, input logic [7:0] d);
    send_byte({2'b10, 6'(a)});
    send_byte(d);
    model_write(a, d);
    $display("[TB] write addr %0d data %02h", a, d);
  endtask

  task automatic read_check(input int a);
    logic [7:0] got;
    send_byte({2'b01, 6'(a)});
    got = bus.data_out;
    check($sformatf("read_latch_a%0d", a), 32'(bus.data_latch), 32'd1);
    check($sformatf("read_data_a%0d", a), 32'(got), 32'(exp_read(a)));
    @(posedge clk);
    #1;
    check($sformatf("latch_drop_a%0d", a), 32'(bus.data_latch), 32'd0);
    $display("[TB] read addr %0d data %02h", a, got);
  endtask

  task automatic count_high(input int ch, input int n, output int highs);
    highs = 0;
    repeat (n) begin
      @(posedge clk);
      #1;
      highs += int'(out[ch]);
    end
  endtask

  // First complete run after the first transition, plus the run that follows it.
  task automatic measure_runs(input int ch, input int n, output int hi, output int lo);
    bit s[$];
    int i, r1, r2;
    s = {};
    repeat (n) begin
      @(posedge clk);
      #1;
      s.push_back(out[ch]);
    end
    hi = 0; lo = 0; i = 1;
    while (i < n && s[i] == s[i-1]) i++;
    if (i >= n) return;
    r1 = 0;
    while (i + r1 < n && s[i+r1] == s[i]) r1++;
    r2 = 0;
    while (i + r1 + r2 < n && s[i+r1+r2] != s[i]) r2++;
    if (s[i]) begin hi = r1; lo = r2; end
    else      begin lo = r1; hi = r2; end
  endtask

  // Classifies complete high pulses as old (3), new (7) or anything else.
  task automatic high_pulses(input int ch, input int n, output int n_bad, output int n_three,
                             output int last);
    int  run;
    bit  seen_low;
    run = 0; seen_low = 0; n_bad = 0; n_three = 0; last = 0;
    repeat (n) begin
      @(posedge clk);
      #1;
      if (out[ch]) run++;
      else begin
        if (run > 0 && seen_low) begin
          if (run == 3) n_three++;
          else if (run != 7) n_bad++;
          last = run;
        end
        run = 0;
        seen_low = 1;
      end
    end
  endtask

  initial begin
    int hi, lo, highs, n_bad, n_three, last;
    int p, s, d, pol, len, expect_high;

    bus.data_in  = '0;
    bus.data_rdy = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset_out", 32'(out), 32'd0);
    check("reset_latch", 32'(bus.data_latch), 32'd0);
    check("reset_dout", 32'(bus.data_out), 32'd0);
    rst = 1'b1;

    read_check(7);
    read_check(63);
    read_check(0);

    // Directed PWM: period 10, duty 3, prescale 0.
    write_csr(0, 8'h00);
    write_csr(1, 8'h00);
    write_csr(2, 8'h00);
    write_csr(3, 8'd9);
    write_csr(8, 8'h00);
    write_csr(9, 8'd3);
    write_csr(5, 8'h01);
    write_csr(0, 8'h05);
    measure_runs(0, 45, hi, lo);
    check("p0_high", 32'(hi), 32'd3);
    check("p0_low", 32'(lo), 32'd7);

    write_csr(1, 8'h01);
    measure_runs(0, 70, hi, lo);
    check("p1_high", 32'(hi), 32'd6);
    check("p1_low", 32'(lo), 32'd14);

    write_csr(6, 8'h01);
    measure_runs(0, 70, hi, lo);
    check("pol_high", 32'(hi), 32'd14);
    check("pol_low", 32'(lo), 32'd6);

    write_csr(6, 8'h00);
    write_csr(1, 8'h00);
    write_csr(9, 8'd7);
    high_pulses(0, 60, n_bad, n_three, last);
    check("duty_chg_runt", 32'(n_bad), 32'd0);
    check("duty_chg_old_le1", 32'(n_three <= 1), 32'd1);
    check("duty_chg_new", 32'(last), 32'd7);
    count_high(0, 10, highs);
    check("duty_chg_window", 32'(highs), 32'd7);

    // Channel edge cases on channel 1.
    write_csr(5, 8'h03);
    repeat (12) @(posedge clk);
    count_high(1, 25, highs);
    check("duty_zero", 32'(highs), 32'd0);
    write_csr(11, 8'd20);
    repeat (12) @(posedge clk);
    count_high(1, 25, highs);
    check("duty_over", 32'(highs), 32'd25);

    write_csr(4, 8'h5A);
    write_csr(0, 8'h03);
    @(posedge clk);
    #1;
    check("gpio_mode_out", 32'(out), 32'h5A);

    // Randomized single-channel configs: high time per full period is arithmetic.
    for (int r = 0; r < 4; r++) begin
      p   = int'($urandom_range(1, 15));
      s   = int'($urandom_range(0, 2));
      d   = int'($urandom_range(0, p + 3));
      pol = int'($urandom_range(0, 1));
      write_csr(0, 8'h00);
      write_csr(1, 8'(s));
      write_csr(2, 8'h00);
      write_csr(3, 8'(p));
      write_csr(8, 8'h00);
      write_csr(9, 8'(d));
      write_csr(6, 8'(pol));
      write_csr(5, 8'h01);
      write_csr(0, 8'h05);
      repeat (4) @(posedge clk);
      len = (p + 1) * (s + 1);
      expect_high = (s + 1) * ((d < p + 1) ? d : p + 1);
      if (pol != 0) expect_high = len - expect_high;
      count_high(0, len, highs);
      check($sformatf("rand_pwm%0d_p%0d_s%0d_d%0d_pol%0d", r, p, s, d, pol),
            32'(highs), 32'(expect_high));
    end

    // Random CSR writes, then full readback of the mapped range and a bit beyond.
    for (int r = 0; r < 12; r++) begin
      write_csr(int'($urandom_range(0, 19)), 8'($urandom_range(0, 255)));
    end
    for (int a = 0; a < 20; a++) read_check(a);

    // Burst at addr 8 with abort.
    send_byte(8'hC8);
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h03);
    send_byte(8'h00);
    model_write(8, 8'h01);
    model_write(9, 8'h02);
    model_write(10, 8'h03);
    $display("[TB] burst addr 8 data 01 02 03 abort");
    read_check(8);
    read_check(9);
    read_check(10);
    read_check(11);
    read_check(7);

    // Reset in the middle of a burst.
    write_csr(0, 8'h02);
    send_byte(8'hC4);
    send_byte(8'hFF);
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check("async_rst_out", 32'(out), 32'd0);
    check("async_rst_latch", 32'(bus.data_latch), 32'd0);
    model_reset();
    #10;
    rst = 1'b1;
    $display("[TB] reset during burst");
    read_check(4);
    read_check(0);
    read_check(8);
    read_check(7);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
